// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin arbiter sharing one register-bus port between requesters
// One transaction in flight at a time, with a watchdog that completes unacked accesses with an error.
module reg_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int REG_ADDR_WIDTH = 16,
  parameter int REG_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_MASTERS-1:0]                   m_reg_req,
  input  logic [NUM_MASTERS*REG_ADDR_WIDTH-1:0]    m_reg_addr,
  input  logic [NUM_MASTERS*REG_DATA_WIDTH-1:0]    m_reg_wdata,
  input  logic [NUM_MASTERS-1:0]                   m_reg_wren,
  input  logic [NUM_MASTERS*REG_DATA_WIDTH/8-1:0]  m_reg_be,
  output logic [NUM_MASTERS-1:0]                   m_reg_ack,
  output logic                                     m_reg_err,
  output logic [REG_DATA_WIDTH-1:0]                m_reg_rdata,
  output logic [REG_ADDR_WIDTH-1:0]                reg_addr,
  output logic [REG_DATA_WIDTH-1:0]                reg_wdata,
  output logic                                     reg_wren,
  output logic [REG_DATA_WIDTH/8-1:0]              reg_be,
  output logic                                     reg_req,
  input  logic                                     reg_ack,
  input  logic                                     reg_err,
  input  logic [REG_DATA_WIDTH-1:0]                reg_rdata,
  output logic [$clog2(NUM_MASTERS)-1:0]           grant,
  output logic                                     busy,
  output logic                                     timeout
);

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int BW = REG_DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                    state_q, state_d;
  logic [GW-1:0]             last_grant_q, last_grant_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic [GW-1:0]             grant_d;
  logic                      busy_d, timeout_d, reg_req_d, reg_wren_d, m_reg_err_d;
  logic [NUM_MASTERS-1:0]    m_reg_ack_d;
  logic [REG_DATA_WIDTH-1:0] m_reg_rdata_d, reg_wdata_d;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_d;
  logic [BW-1:0]             reg_be_d;

  logic [REG_ADDR_WIDTH-1:0] addr_arr  [NUM_MASTERS];
  logic [REG_DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];
  logic [BW-1:0]             be_arr    [NUM_MASTERS];

  logic                      sel_valid;
  logic [GW-1:0]             sel_idx;
  logic [GW-1:0]             cand;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      addr_arr[i]  = m_reg_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      wdata_arr[i] = m_reg_wdata[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
      be_arr[i]    = m_reg_be[i*BW +: BW];
    end
  end

  // Search starts one past the last winner so the previous owner has lowest priority.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_MASTERS);
      if (!sel_valid && m_reg_req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    grant_d       = grant;
    reg_addr_d    = reg_addr;
    reg_wdata_d   = reg_wdata;
    reg_wren_d    = reg_wren;
    reg_be_d      = reg_be;
    m_reg_err_d   = m_reg_err;
    m_reg_rdata_d = m_reg_rdata;
    reg_req_d     = 1'b0;
    m_reg_ack_d   = '0;
    timeout_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          grant_d     = sel_idx;
          reg_addr_d  = addr_arr[sel_idx];
          reg_wdata_d = wdata_arr[sel_idx];
          reg_wren_d  = m_reg_wren[sel_idx];
          reg_be_d    = be_arr[sel_idx];
          reg_req_d   = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (reg_ack) begin
          m_reg_rdata_d      = reg_rdata;
          m_reg_err_d        = reg_err;
          m_reg_ack_d[grant] = 1'b1;
          state_d            = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A real ack on the terminal count takes priority over the watchdog.
        if (reg_ack) begin
          m_reg_rdata_d      = reg_rdata;
          m_reg_err_d        = reg_err;
          m_reg_ack_d[grant] = 1'b1;
          state_d            = RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          m_reg_rdata_d      = '0;
          m_reg_err_d        = 1'b1;
          m_reg_ack_d[grant] = 1'b1;
          timeout_d          = 1'b1;
          state_d            = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        last_grant_d = grant;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_MASTERS - 1);
      cnt_q        <= '0;
      grant        <= '0;
      busy         <= 1'b0;
      timeout      <= 1'b0;
      reg_req      <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_wren     <= 1'b0;
      reg_be       <= '0;
      m_reg_ack    <= '0;
      m_reg_err    <= 1'b0;
      m_reg_rdata  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      grant        <= grant_d;
      busy         <= busy_d;
      timeout      <= timeout_d;
      reg_req      <= reg_req_d;
      reg_addr     <= reg_addr_d;
      reg_wdata    <= reg_wdata_d;
      reg_wren     <= reg_wren_d;
      reg_be       <= reg_be_d;
      m_reg_ack    <= m_reg_ack_d;
      m_reg_err    <= m_reg_err_d;
      m_reg_rdata  <= m_reg_rdata_d;
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - directed vector bench for reg_bus_arbiter
// Two requesters, TIMEOUT_CYCLES=8; cycle tables plus hand-written multi-cycle sequences.
module tb_reg_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_reg_req;
  logic [31:0] m_reg_addr;
  logic [63:0] m_reg_wdata;
  logic [1:0]  m_reg_wren;
  logic [7:0]  m_reg_be;
  logic [1:0]  m_reg_ack;
  logic        m_reg_err;
  logic [31:0] m_reg_rdata;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wren;
  logic [3:0]  reg_be;
  logic        reg_req;
  logic        reg_ack;
  logic        reg_err;
  logic [31:0] reg_rdata;
  logic        grant;
  logic        busy;
  logic        timeout;

  int passed = 0;
  int total  = 0;

  reg_bus_arbiter #(
    .NUM_MASTERS(2), .REG_ADDR_WIDTH(16), .REG_DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_reg_req(m_reg_req), .m_reg_addr(m_reg_addr), .m_reg_wdata(m_reg_wdata),
    .m_reg_wren(m_reg_wren), .m_reg_be(m_reg_be),
    .m_reg_ack(m_reg_ack), .m_reg_err(m_reg_err), .m_reg_rdata(m_reg_rdata),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wren(reg_wren), .reg_be(reg_be),
    .reg_req(reg_req), .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata),
    .grant(grant), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        e_req;
    logic [1:0]  e_mack;
    logic        e_err;
    logic [31:0] e_rdata;
    logic        e_busy;
    logic        e_grant;
    logic        e_wren;
    logic [3:0]  e_be;
    logic [15:0] e_addr;
    logic        e_to;
  } vec_t;

  vec_t vt [10];

  int seq_grant [6];
  int n, acks, reqs, low_run, gaps, to_cnt, bad;
  bit got;

  initial begin
    // Requester 0: read 0x0004, be=F. Requester 1: write 0xA5A5A5A5 to 0x0010, be=0011.
    rst         = 1'b1;
    m_reg_req   = 2'b00;
    m_reg_addr  = {16'h0010, 16'h0004};
    m_reg_wdata = {32'hA5A5A5A5, 32'h11111111};
    m_reg_wren  = 2'b10;
    m_reg_be    = {4'b0011, 4'b1111};
    reg_ack     = 1'b0;
    reg_err     = 1'b0;
    reg_rdata   = 32'h0;

    // Inputs of row i are applied during cycle i; expectations are for cycle i+1.
    vt[0] = '{2'b01, 1'b0, 1'b0, 32'h0,        1'b1, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'hF, 16'h0004, 1'b0};
    vt[1] = '{2'b01, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'hF, 16'h0004, 1'b0};
    vt[2] = '{2'b01, 1'b1, 1'b0, 32'h0000FFFF, 1'b0, 2'b01, 1'b0, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 4'hF, 16'h0004, 1'b0};
    vt[3] = '{2'b01, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'hF, 16'h0004, 1'b0};
    vt[4] = '{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'hF, 16'h0004, 1'b0};
    vt[5] = '{2'b10, 1'b0, 1'b0, 32'h0,        1'b1, 2'b00, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 4'h3, 16'h0010, 1'b0};
    vt[6] = '{2'b10, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 4'h3, 16'h0010, 1'b0};
    vt[7] = '{2'b10, 1'b1, 1'b1, 32'h12345678, 1'b0, 2'b10, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1, 4'h3, 16'h0010, 1'b0};
    vt[8] = '{2'b10, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 4'h3, 16'h0010, 1'b0};
    vt[9] = '{2'b00, 1'b1, 1'b0, 32'h0BADBAD0, 1'b0, 2'b00, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 4'h3, 16'h0010, 1'b0};

    seq_grant = '{0, 1, 0, 1, 0, 1};

    step; step; step;
    rst = 1'b0;
    chk("rst_m_ack", m_reg_ack, 2'b00);
    chk("rst_reg_req", reg_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_reg_addr", reg_addr, 16'h0);
    chk("rst_rdata", m_reg_rdata, 32'h0);

    for (int i = 0; i < 10; i++) begin
      m_reg_req = vt[i].req;
      reg_ack   = vt[i].ack;
      reg_err   = vt[i].err;
      reg_rdata = vt[i].rdata;
      step;
      chk($sformatf("vec%0d_reg_req", i), reg_req, vt[i].e_req);
      chk($sformatf("vec%0d_m_ack", i), m_reg_ack, vt[i].e_mack);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("vec%0d_grant", i), grant, vt[i].e_grant);
      chk($sformatf("vec%0d_wren", i), reg_wren, vt[i].e_wren);
      chk($sformatf("vec%0d_be", i), reg_be, vt[i].e_be);
      chk($sformatf("vec%0d_addr", i), reg_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_timeout", i), timeout, vt[i].e_to);
      if (vt[i].e_mack != 2'b00) begin
        chk($sformatf("vec%0d_err", i), m_reg_err, vt[i].e_err);
        chk($sformatf("vec%0d_rdata", i), m_reg_rdata, vt[i].e_rdata);
      end
    end
    chk("wdata_hold", reg_wdata, 32'hA5A5A5A5);
    reg_ack = 1'b0;

    // Round robin under continuous demand; downstream acks one cycle after each strobe.
    m_reg_req = 2'b11;
    acks = 0; reqs = 0; low_run = 0; gaps = 0; n = 0;
    reg_rdata = 32'h00C0FFEE;
    while (acks < 6 && n < 80) begin
      step;
      n++;
      if (reg_req) begin
        if (reqs < 6) chk($sformatf("rr_grant%0d", reqs), grant, seq_grant[reqs]);
        reqs++;
      end
      if (m_reg_ack != 2'b00) begin
        chk($sformatf("rr_ack_route%0d", acks), m_reg_ack, grant ? 2'b10 : 2'b01);
        acks++;
        if (acks == 6) m_reg_req = 2'b00;
      end
      if (busy) begin
        if (low_run > 0 && reqs > 1) begin
          chk("rr_busy_gap", low_run, 1);
          gaps++;
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      reg_ack = reg_req;
    end
    chk("rr_acks", acks, 6);
    chk("rr_reqs", reqs, 6);
    chk("rr_gaps", gaps, 5);
    reg_ack = 1'b0;
    step;

    // Watchdog: requester 0, downstream silent.
    m_reg_req = 2'b01;
    reg_rdata = 32'hDEADBEEF;
    step;
    chk("to_issue_req", reg_req, 1'b1);
    chk("to_issue_grant", grant, 1'b0);
    n = 0; to_cnt = 0; got = 1'b0;
    while (!got && n < 30) begin
      step;
      n++;
      if (timeout) to_cnt++;
      if (m_reg_ack != 2'b00) begin
        got = 1'b1;
        chk("to_latency", n, 9);
        chk("to_m_ack", m_reg_ack, 2'b01);
        chk("to_err", m_reg_err, 1'b1);
        chk("to_rdata", m_reg_rdata, 32'h0);
        chk("to_pulse_with_ack", timeout, 1'b1);
        m_reg_req = 2'b00;
      end
    end
    chk("to_done", got, 1'b1);
    step; step;
    reg_ack = 1'b1;
    reg_rdata = 32'h5555AAAA;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      reg_ack = 1'b0;
      if (m_reg_ack != 2'b00 || busy) bad++;
      if (timeout) to_cnt++;
    end
    chk("to_stray_ignored", bad, 0);
    chk("to_pulse_count", to_cnt, 1);

    // Ack on the terminal WAIT cycle beats the watchdog.
    m_reg_req = 2'b10;
    step;
    chk("term_issue_grant", grant, 1'b1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step;
      if (m_reg_ack != 2'b00 || timeout || !busy) bad++;
    end
    chk("term_wait_quiet", bad, 0);
    reg_ack = 1'b1;
    reg_err = 1'b0;
    reg_rdata = 32'hCAFEF00D;
    step;
    chk("term_m_ack", m_reg_ack, 2'b10);
    chk("term_err", m_reg_err, 1'b0);
    chk("term_rdata", m_reg_rdata, 32'hCAFEF00D);
    chk("term_no_timeout", timeout, 1'b0);
    reg_ack = 1'b0;
    m_reg_req = 2'b00;
    step;

    // Reset during WAIT abandons the transaction.
    m_reg_req = 2'b10;
    step;
    chk("rw_issue_grant", grant, 1'b1);
    step;
    chk("rw_wait_busy", busy, 1'b1);
    m_reg_req = 2'b00;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rw_grant", grant, 1'b0);
    chk("rw_busy", busy, 1'b0);
    chk("rw_reg_req", reg_req, 1'b0);
    chk("rw_m_ack", m_reg_ack, 2'b00);
    chk("rw_addr", reg_addr, 16'h0);
    chk("rw_wdata", reg_wdata, 32'h0);
    chk("rw_wren_be", {reg_wren, reg_be}, 5'h0);
    chk("rw_rdata", m_reg_rdata, 32'h0);
    reg_ack = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step;
      reg_ack = 1'b0;
      if (m_reg_ack != 2'b00 || busy) bad++;
    end
    chk("rw_no_ack", bad, 0);
    m_reg_req = 2'b10;
    step;
    chk("rw_new_req", reg_req, 1'b1);
    chk("rw_new_grant", grant, 1'b1);
    chk("rw_new_addr", reg_addr, 16'h0010);
    step;
    reg_ack = 1'b1;
    reg_err = 1'b0;
    reg_rdata = 32'h13579BDF;
    step;
    reg_ack = 1'b0;
    m_reg_req = 2'b00;
    chk("rw_new_m_ack", m_reg_ack, 2'b10);
    chk("rw_new_rdata", m_reg_rdata, 32'h13579BDF);
    step;
    chk("rw_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
